rr_arb_mux: RTL

- Parametrised N-channel, WIDTH-bit arbitrating multiplexer with a registered output stage and valid/ready handshakes.
- Generalises the fixed 4:1 32-bit select mux: the select is produced internally by a round-robin or fixed-priority arbiter rather than driven externally.
- Sits between multiple requesters (e.g. fetch/load/store/debug sources) and a single shared consumer such as a memory port or writeback bus.

---
 rtl/rr_arb_mux.sv | 94 +++++++++
 1 files changed

// File: rtl/rr_arb_mux.sv
// N-channel arbitrating multiplexer with a registered output stage.
// Round-robin (RR=1) or fixed-priority (RR=0) grant with valid/ready handshakes.
module rr_arb_mux #(
    parameter int WIDTH = 32,
    parameter int N     = 4,
    parameter int RR    = 1,
    parameter int SELW  = (N > 1) ? $clog2(N) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         in_valid,
    input  logic [N*WIDTH-1:0]   in_data,
    output logic [N-1:0]         in_ready,
    output logic                 out_valid,
    output logic [WIDTH-1:0]     out_data,
    output logic [SELW-1:0]      out_sel,
    input  logic                 out_ready
);

    logic [WIDTH-1:0] w_chanData [N];
    logic             w_loadEn;
    logic             w_found;
    logic [SELW-1:0]  w_grant;
    logic [N-1:0]     w_ready;
    logic             w_xfer;

    logic             r_outValid;
    logic [WIDTH-1:0] r_outData;
    logic [SELW-1:0]  r_outSel;
    logic [SELW-1:0]  r_ptr;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_chan
            assign w_chanData[gi] = in_data[gi*WIDTH +: WIDTH];
        end
    endgenerate

    assign w_loadEn = !r_outValid || out_ready;

    // Search starts at the pointer in round-robin mode, at channel 0 otherwise.
    always_comb begin
        int base;
        int idx;
        w_found = 1'b0;
        w_grant = '0;
        idx     = 0;
        base    = (RR != 0) ? int'(r_ptr) : 0;
        for (int k = 0; k < N; k++) begin
            idx = base + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (!w_found && in_valid[idx[SELW-1:0]]) begin
                w_found = 1'b1;
                w_grant = idx[SELW-1:0];
            end
        end
    end

    always_comb begin
        w_ready = '0;
        if (w_found && w_loadEn && !rst) begin
            w_ready[w_grant] = 1'b1;
        end
    end

    assign w_xfer   = |w_ready;
    assign in_ready = w_ready;

    // A new beat takes priority over draining, so back-to-back transfers leave no bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_outValid <= 1'b0;
            r_outData  <= '0;
            r_outSel   <= '0;
            r_ptr      <= '0;
        end else if (w_xfer) begin
            r_outValid <= 1'b1;
            r_outData  <= w_chanData[w_grant];
            r_outSel   <= w_grant;
            if (RR != 0) begin
                r_ptr <= (w_grant == SELW'(N-1)) ? '0 : w_grant + 1'b1;
            end
        end else if (r_outValid && out_ready) begin
            r_outValid <= 1'b0;
        end
    end

    assign out_valid = r_outValid;
    assign out_data  = r_outData;
    assign out_sel   = r_outSel;

endmodule
